// File: rtl/mips_exec_ctrl.sv
// Single-cycle MIPS execute/control slice: main and ALU decode,
// operand-B select, 32-bit ALU and a registered result/zero status copy.
module mips_exec_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] rd2,
  input  logic [WIDTH-1:0] sign_imm,
  output logic             mem_to_reg,
  output logic             mem_write,
  output logic             branch,
  output logic             alu_src,
  output logic             reg_dst,
  output logic             reg_write,
  output logic [2:0]       alu_control,
  output logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             pc_src,
  output logic [WIDTH-1:0] alu_result_q,
  output logic             zero_q
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  logic [1:0] aluop;
  logic       reg_write_main;
  logic       funct_bad;

  always_comb begin
    reg_write_main = 1'b0;
    reg_dst        = 1'b0;
    alu_src        = 1'b0;
    branch         = 1'b0;
    mem_write      = 1'b0;
    mem_to_reg     = 1'b0;
    aluop          = 2'b00;
    unique case (1'b1)
      (opcode == OP_RTYPE): begin
        reg_write_main = 1'b1;
        reg_dst        = 1'b1;
        aluop          = 2'b10;
      end
      (opcode == OP_LW): begin
        reg_write_main = 1'b1;
        alu_src        = 1'b1;
        mem_to_reg     = 1'b1;
      end
      (opcode == OP_SW): begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      (opcode == OP_BEQ): begin
        branch = 1'b1;
        aluop  = 2'b01;
      end
      (opcode == OP_ADDI): begin
        reg_write_main = 1'b1;
        alu_src        = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_control = 3'b010;
    funct_bad   = 1'b0;
    unique case (aluop)
      2'b00: alu_control = 3'b010;
      2'b01: alu_control = 3'b110;
      2'b10: begin
        unique case (1'b1)
          (funct == FN_ADD): alu_control = 3'b010;
          (funct == FN_SUB): alu_control = 3'b110;
          (funct == FN_AND): alu_control = 3'b000;
          (funct == FN_OR):  alu_control = 3'b001;
          (funct == FN_SLT): alu_control = 3'b111;
          default: begin
            alu_control = 3'b000;
            funct_bad   = 1'b1;
          end
        endcase
      end
      default: alu_control = 3'b010;
    endcase
  end

  // Unsupported R-type functs must not write the register file.
  assign reg_write = reg_write_main & ~funct_bad;

  assign src_b = alu_src ? sign_imm : rd2;

  always_comb begin
    alu_result = '0;
    unique case (alu_control)
      3'b000: alu_result = src_a & src_b;
      3'b001: alu_result = src_a | src_b;
      3'b010: alu_result = src_a + src_b;
      3'b100: alu_result = src_a & ~src_b;
      3'b101: alu_result = src_a | ~src_b;
      3'b110: alu_result = src_a - src_b;
      3'b111: alu_result = {{(WIDTH-1){1'b0}},
                            ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  assign zero   = (alu_result == '0);
  assign pc_src = branch & zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_q <= '0;
      zero_q       <= 1'b0;
    end else begin
      alu_result_q <= alu_result;
      zero_q       <= zero;
    end
  end

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Directed bench for mips_exec_ctrl: decode, ALU, branch
// and asynchronous reset of the status register.
module tb_mips_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic [31:0] src_a, rd2, sign_imm;
  logic        mem_to_reg, mem_write, branch;
  logic        alu_src, reg_dst, reg_write;
  logic [2:0]  alu_control;
  logic [31:0] src_b, alu_result, alu_result_q;
  logic        zero, pc_src, zero_q;

  int checks = 0;
  int failures = 0;

  mips_exec_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .opcode(opcode), .funct(funct),
    .src_a(src_a), .rd2(rd2), .sign_imm(sign_imm),
    .mem_to_reg(mem_to_reg), .mem_write(mem_write),
    .branch(branch), .alu_src(alu_src),
    .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_control(alu_control), .src_b(src_b),
    .alu_result(alu_result), .zero(zero),
    .pc_src(pc_src), .alu_result_q(alu_result_q),
    .zero_q(zero_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {reg_write,reg_dst,alu_src,branch,mem_write,mem_to_reg}
  function automatic logic [31:0] ctl();
    return {26'd0, reg_write, reg_dst, alu_src,
            branch, mem_write, mem_to_reg};
  endfunction

  task automatic drive(input logic [5:0] op,
                       input logic [5:0] fn,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] imm);
    @(negedge clk);
    opcode = op; funct = fn;
    src_a = a; rd2 = b; sign_imm = imm;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 6'd0; funct = 6'd0;
    src_a = '0; rd2 = '0; sign_imm = '0;
    #2;
    chk("rst_res_q", alu_result_q, 32'd0);
    chk("rst_zero_q", {31'd0, zero_q}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // R-type add
    drive(6'b000000, 6'b100000, 32'd5, 32'd7, 32'd0);
    chk("add_ctl", ctl(), 32'b110000);
    chk("add_aluc", {29'd0, alu_control}, 32'd2);
    chk("add_srcb", src_b, 32'd7);
    chk("add_res", alu_result, 32'd12);
    chk("add_zero", {31'd0, zero}, 32'd0);
    @(posedge clk); #1;
    chk("add_res_q", alu_result_q, 32'd12);
    chk("add_zero_q", {31'd0, zero_q}, 32'd0);

    // Async reset between edges, held over an edge, then released
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_res_q", alu_result_q, 32'd0);
    chk("arst_zero_q", {31'd0, zero_q}, 32'd0);
    chk("arst_comb", alu_result, 32'd12);
    @(posedge clk); #1;
    chk("arst_hold", alu_result_q, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_rel_pre", alu_result_q, 32'd0);
    @(posedge clk); #1;
    chk("arst_rel", alu_result_q, 32'd12);

    // lw
    drive(6'b100011, 6'b000000, 32'h100, 32'h55, 32'hFFFFFFFC);
    chk("lw_ctl", ctl(), 32'b101001);
    chk("lw_srcb", src_b, 32'hFFFFFFFC);
    chk("lw_res", alu_result, 32'h000000FC);

    // addi wraps
    drive(6'b001000, 6'b000000, 32'h7FFFFFFF, 32'h55, 32'd1);
    chk("addi_ctl", ctl(), 32'b101000);
    chk("addi_res", alu_result, 32'h80000000);

    // beq taken
    drive(6'b000100, 6'b000000, 32'd9, 32'd9, 32'd0);
    chk("beq_ctl", ctl(), 32'b000100);
    chk("beq_aluc", {29'd0, alu_control}, 32'd6);
    chk("beq_zero", {31'd0, zero}, 32'd1);
    chk("beq_pcsrc", {31'd0, pc_src}, 32'd1);
    @(posedge clk); #1;
    chk("beq_zero_q", {31'd0, zero_q}, 32'd1);
    chk("beq_res_q", alu_result_q, 32'd0);

    // beq not taken
    drive(6'b000100, 6'b000000, 32'd9, 32'd8, 32'd0);
    chk("bne_res", alu_result, 32'd1);
    chk("bne_pcsrc", {31'd0, pc_src}, 32'd0);

    // sw with equal address/zero result must not branch
    drive(6'b101011, 6'b000000, 32'd4, 32'd3, 32'hFFFFFFFC);
    chk("sw_ctl", ctl(), 32'b001010);
    chk("sw_res", alu_result, 32'd0);
    chk("sw_pcsrc", {31'd0, pc_src}, 32'd0);

    // and / or / slt
    drive(6'b000000, 6'b100100, 32'h0000F0F0, 32'h00000FF0, 32'd0);
    chk("and_aluc", {29'd0, alu_control}, 32'd0);
    chk("and_res", alu_result, 32'h000000F0);
    drive(6'b000000, 6'b100101, 32'h0000F0F0, 32'h00000FF0, 32'd0);
    chk("or_aluc", {29'd0, alu_control}, 32'd1);
    chk("or_res", alu_result, 32'h0000FFF0);
    drive(6'b000000, 6'b100010, 32'd3, 32'd5, 32'd0);
    chk("sub_res", alu_result, 32'hFFFFFFFE);
    drive(6'b000000, 6'b101010, 32'hFFFFFFFF, 32'd1, 32'd0);
    chk("slt_aluc", {29'd0, alu_control}, 32'd7);
    chk("slt_res", alu_result, 32'd1);
    chk("slt_zero", {31'd0, zero}, 32'd0);
    drive(6'b000000, 6'b101010, 32'd1, 32'hFFFFFFFF, 32'd0);
    chk("slt_sw_res", alu_result, 32'd0);
    chk("slt_sw_zero", {31'd0, zero}, 32'd1);

    // Illegal opcode and illegal funct
    drive(6'b111111, 6'b100010, 32'd2, 32'd3, 32'd100);
    chk("ill_op_ctl", ctl(), 32'd0);
    chk("ill_op_aluc", {29'd0, alu_control}, 32'd2);
    chk("ill_op_res", alu_result, 32'd5);
    drive(6'b000000, 6'b000000, 32'hFF, 32'h0F, 32'd0);
    chk("ill_fn_ctl", ctl(), 32'b010000);
    chk("ill_fn_aluc", {29'd0, alu_control}, 32'd0);
    chk("ill_fn_res", alu_result, 32'h0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
